regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single register-file write port (`we`/`waddr`/`wdata`) between two writeback sources: port A (ALU/EX results) and port B (load/MEM results). Each source has a 2-entry FIFO behind a valid/ready handshake. A round-robin arbiter drains the FIFOs into the write port. Pending-write lookups let decode stall on hazards against buffered writes.

## Interface
- `DEPTH`, 2: entries per source FIFO (power of two, ≥2)
- `clk` in 1: clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low; clears all state
- `rdy` in 1: global pause; low freezes all state and forces every output handshake low
- `a_valid` in 1, `a_addr` in 5, `a_data` in 32, `a_ready` out 1: source A write request
- `b_valid` in 1, `b_addr` in 5, `b_data` in 32, `b_ready` out 1: source B write request
- `we` out 1, `waddr` out 5, `wdata` out 32: to register file write port
- `q1_addr` in 5, `q1_pend` out 1; `q2_addr` in 5, `q2_pend` out 1: pending-write lookups
- `idle` out 1: both FIFOs empty

## Operation
- Transfer on X: `X_valid & X_ready & rdy` at a rising edge.
- `X_ready = rdy & (count_X < DEPTH)`.
- An accepted write with `addr == 0` is discarded: it is not queued and never produces `we`.
- Candidate for X: FIFO head if `count_X != 0`; otherwise the bypass input (see Configuration).
- Arbitration:
  - One candidate present: it is granted.
  - Both present: grant the source other than `rr_last`.
  - `rr_last` updates to the granted source at the edge.
- Output: `we = rdy & grant_any`; `waddr`/`wdata` come from the granted candidate and are combinational from the FIFO heads. A granted FIFO head pops at the same edge.
- Push and pop on one FIFO in the same cycle is legal; the count is unchanged. Pointers wrap modulo `DEPTH`.
- Per-source FIFO order is preserved. Between sources, a same-address pair has no defined order; producers must not rely on it.
- `qN_pend = 1` iff `qN_addr != 0` and any valid entry in either FIFO has that address. In-flight inputs are not checked.
- `idle = (count_A == 0) & (count_B == 0)`.

## Timing
- Reset values: `we=0`, `waddr=0`, `wdata=0`, `a_ready=0`, `b_ready=0`, `q*_pend=0`, `idle=1`, `rr_last=B` (A wins the first tie), counts and pointers 0.
- After `rst_n` deasserts, ready is high in the first cycle with `rdy=1`.
- Latency without bypass: accepted at edge N, `we` asserted during cycle N+1 at the earliest.
- Throughput: one register write per cycle. With both sources saturated, grants alternate A, B, A, B…
- `rdy=0` mid-stream: `we=0`, no push, no pop, `rr_last` held. Operation resumes with identical state.
- `rst_n` asserted mid-operation: queued writes are lost and outputs return to reset values immediately.
- `we` is only ever asserted while `rdy=1`.

## Configuration
- `WB_BYPASS_EN` defined:
  - An empty FIFO presents its valid, nonzero-addressed input as a candidate in the same cycle.
  - If granted, the entry is written through (`we` in cycle N, zero latency) and not pushed.
  - If not granted, it is pushed normally.
- `WB_BYPASS_EN` undefined: candidates come only from FIFO heads; minimum latency is 1 cycle.
- Port list and reset behaviour are identical in both builds.

## Test plan
- Reset: hold `rst_n=0`, drive `a_valid=1` → `we=0`, `a_ready=0`, `idle=1`. Release → `a_ready=1` next cycle with `rdy=1`.
- Single write: A sends addr 5, data 0x1234 at edge N → `we=1`, `waddr=5`, `wdata=0x1234` in cycle N+1 (cycle N with `WB_BYPASS_EN`); `idle=1` afterwards.
- Contention: both sources stream 4 writes each (A addrs 1–4, B addrs 11–14) → `we` every cycle, order 1, 11, 2, 12, 3, 13, 4, 14; no write lost.
- Full/backpressure: hold `rdy=1` but force continuous B traffic, push 3 entries into A with no A grants → `a_ready=0` after 2 entries. Third entry accepted the cycle after A's first pop.
- x0 and pending: A writes addr 0 then addr 7, `q1_addr=7`, `q2_addr=0` → no `we` for addr 0. `q1_pend=1` while addr 7 is queued, `q2_pend=0` always.
- Pause/reset mid-stream: `rdy=0` for 3 cycles with 2 queued entries → `we=0` and counts held, then resume in order. `rst_n` pulse while queued → queue emptied, `idle=1`.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between two
// writeback sources (A = EX/ALU results, B = MEM/load results).
// Each source is buffered in a DEPTH-entry FIFO and the FIFO heads are
// drained round-robin, one register write per cycle.
// Optional feature macro: WB_BYPASS_EN. When defined, an empty FIFO offers
// its incoming (valid, nonzero-address) write as a same-cycle candidate.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic [4:0]  q1_addr,
  output logic        q1_pend,
  input  logic [4:0]  q2_addr,
  output logic        q2_pend,
  output logic        idle
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;

  // Index 0 is source A, index 1 is source B throughout.
  src_t          rr_last;
  logic [1:0]    in_valid;
  logic [4:0]    in_addr  [2];
  logic [31:0]   in_data  [2];
  logic [4:0]    mem_addr [2][DEPTH];
  logic [31:0]   mem_data [2][DEPTH];
  logic [PW-1:0] wptr     [2];
  logic [PW-1:0] rptr     [2];
  logic [CW-1:0] count    [2];
  logic [1:0]    empty;
  logic [1:0]    ready;
  logic [1:0]    cand;
  logic [1:0]    grant;
  logic [1:0]    push;
  logic [1:0]    pop;

  assign in_valid   = {b_valid, a_valid};
  assign in_addr[0] = a_addr;
  assign in_addr[1] = b_addr;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;

  assign a_ready = ready[0];
  assign b_ready = ready[1];
  assign idle    = empty[0] & empty[1];

  // Per-source ready and arbitration candidates; everything is held off while paused or in reset
  always_comb begin
    empty = '0;
    ready = '0;
    cand  = '0;
    for (int s = 0; s < 2; s++) begin
      empty[s] = (count[s] == '0);
      ready[s] = rst_n & rdy & (count[s] < FULL_COUNT);
`ifdef WB_BYPASS_EN
      cand[s]  = rst_n & rdy & (!empty[s] | (in_valid[s] & (in_addr[s] != 5'd0)));
`else
      cand[s]  = rst_n & rdy & !empty[s];
`endif
    end
  end

  // Round-robin grant: on a tie the source that did not win last time goes
  always_comb begin
    grant = '0;
    if (cand[0] && (!cand[1] || rr_last == SRC_B)) begin
      grant[0] = 1'b1;
    end else if (cand[1]) begin
      grant[1] = 1'b1;
    end
  end

  // Write port driven straight from the granted FIFO head (or the bypassed input when the FIFO is empty)
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    for (int s = 0; s < 2; s++) begin
      if (grant[s]) begin
        we = 1'b1;
        if (empty[s]) begin
          waddr = in_addr[s];
          wdata = in_data[s];
        end else begin
          waddr = mem_addr[s][rptr[s]];
          wdata = mem_data[s][rptr[s]];
        end
      end
    end
  end

  // FIFO push/pop decisions; x0 writes and written-through bypass entries are never stored
  always_comb begin
    push = '0;
    pop  = '0;
    for (int s = 0; s < 2; s++) begin
      pop[s]  = grant[s] & !empty[s];
      push[s] = in_valid[s] & ready[s] & (in_addr[s] != 5'd0) & !(grant[s] & empty[s]);
    end
  end

  // Pending-write lookup; a stored address of zero marks a free slot, so only live entries can match
  always_comb begin
    q1_pend = 1'b0;
    q2_pend = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (q1_addr != 5'd0 && mem_addr[s][e] == q1_addr) q1_pend = 1'b1;
        if (q2_addr != 5'd0 && mem_addr[s][e] == q2_addr) q2_pend = 1'b1;
      end
    end
  end

  // FIFO storage, pointers, occupancy and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= SRC_B;
      for (int s = 0; s < 2; s++) begin
        wptr[s]  <= '0;
        rptr[s]  <= '0;
        count[s] <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem_addr[s][e] <= '0;
          mem_data[s][e] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (pop[s]) begin
          mem_addr[s][rptr[s]] <= '0;
          rptr[s]              <= rptr[s] + PW'(1);
        end
        if (push[s]) begin
          mem_addr[s][wptr[s]] <= in_addr[s];
          mem_data[s][wptr[s]] <= in_data[s];
          wptr[s]              <= wptr[s] + PW'(1);
        end
        if (push[s] && !pop[s]) begin
          count[s] <= count[s] + CW'(1);
        end else if (pop[s] && !push[s]) begin
          count[s] <= count[s] - CW'(1);
        end
      end
      if (grant[0]) begin
        rr_last <= SRC_A;
      end else if (grant[1]) begin
        rr_last <= SRC_B;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven bench for regfile_wb_arbiter (default
// build, DEPTH=2). Each table row drives one cycle of inputs and lists the
// expected handshakes, lookups, idle and which source is granted; written
// address/data come from per-source scoreboard queues filled on acceptance.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  q1_addr;
  logic        q1_pend;
  logic [4:0]  q2_addr;
  logic        q2_pend;
  logic        idle;

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .q1_addr(q1_addr), .q1_pend(q1_pend), .q2_addr(q2_addr), .q2_pend(q2_pend),
    .idle(idle)
  );

  typedef struct {
    logic        rdy;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        ea;
    logic        eb;
    logic [1:0]  eg;
    logic        ep1;
    logic        ep2;
    logic        eidle;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [1:0] G0 = 2'd0;
  localparam logic [1:0] GA = 2'd1;
  localparam logic [1:0] GB = 2'd2;

  vec_t vecs[$];
  wr_t  sbA[$];
  wr_t  sbB[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addVec(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                 input logic [4:0] q1, input logic [4:0] q2,
                                 input logic ea, input logic eb, input logic [1:0] eg,
                                 input logic p1, input logic p2, input logic ei);
    vec_t v;
    v.rdy = r;   v.av = av;  v.aa = aa;  v.ad = ad;
    v.bv = bv;   v.ba = ba;  v.bd = bd;
    v.q1 = q1;   v.q2 = q2;
    v.ea = ea;   v.eb = eb;  v.eg = eg;
    v.ep1 = p1;  v.ep2 = p2; v.eidle = ei;
    vecs.push_back(v);
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rdy     = v.rdy;
    a_valid = v.av;
    a_addr  = v.aa;
    a_data  = v.ad;
    b_valid = v.bv;
    b_addr  = v.ba;
    b_data  = v.bd;
    q1_addr = v.q1;
    q2_addr = v.q2;
  endtask

  // Checks the row's expectations, retires the granted write from its
  // source queue, then records any write the row expects to be accepted.
  task automatic checkOutput(input vec_t v, input int idx);
    wr_t exp;
    compare($sformatf("row%0d a_ready", idx), 32'(a_ready), 32'(v.ea));
    compare($sformatf("row%0d b_ready", idx), 32'(b_ready), 32'(v.eb));
    compare($sformatf("row%0d we", idx), 32'(we), 32'(v.eg != G0));
    compare($sformatf("row%0d q1_pend", idx), 32'(q1_pend), 32'(v.ep1));
    compare($sformatf("row%0d q2_pend", idx), 32'(q2_pend), 32'(v.ep2));
    compare($sformatf("row%0d idle", idx), 32'(idle), 32'(v.eidle));
    if (v.eg != G0) begin
      if ((v.eg == GA && sbA.size() == 0) || (v.eg == GB && sbB.size() == 0)) begin
        checks++;
        errors++;
        $display("[TB] FAIL row%0d scoreboard: actual=empty queue required=queued write", idx);
      end else begin
        if (v.eg == GA) exp = sbA.pop_front();
        else            exp = sbB.pop_front();
        compare($sformatf("row%0d waddr", idx), 32'(waddr), 32'(exp.addr));
        compare($sformatf("row%0d wdata", idx), wdata, exp.data);
      end
    end
    if (v.av && v.ea && v.aa != 5'd0) sbA.push_back('{addr: v.aa, data: v.ad});
    if (v.bv && v.eb && v.ba != 5'd0) sbB.push_back('{addr: v.ba, data: v.bd});
  endtask

  task automatic runRows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
    end
  endtask

  initial begin
    int segEnd;

    // Contention: A addrs 1-4 and B addrs 11-14 stream together; grants alternate A,B from reset
    //     r  av aa     ad          bv ba     bd          q1     q2     ea eb eg  p1 p2 idle
    addVec(T, T, 5'd1,  32'hA001,   T, 5'd11, 32'hB011,   5'd0,  5'd0,  T, T, G0, F, F, T);
    addVec(T, T, 5'd2,  32'hA002,   T, 5'd12, 32'hB012,   5'd0,  5'd0,  T, T, GA, F, F, F);
    addVec(T, T, 5'd3,  32'hA003,   T, 5'd13, 32'hB013,   5'd0,  5'd0,  T, F, GB, F, F, F);
    addVec(T, T, 5'd4,  32'hA004,   T, 5'd13, 32'hB013,   5'd0,  5'd0,  F, T, GA, F, F, F);
    addVec(T, T, 5'd4,  32'hA004,   T, 5'd14, 32'hB014,   5'd0,  5'd0,  T, F, GB, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      T, 5'd14, 32'hB014,   5'd0,  5'd0,  F, T, GA, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd0,  5'd0,  T, F, GB, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd0,  5'd0,  T, T, GA, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd0,  5'd0,  T, T, GB, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd0,  5'd0,  T, T, G0, F, F, T);
    // Single write: addr 5 / 0x1234 written the cycle after acceptance
    addVec(T, T, 5'd5,  32'h1234,   F, 5'd0,  32'h0,      5'd5,  5'd0,  T, T, G0, F, F, T);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd5,  5'd0,  T, T, GA, T, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd5,  5'd0,  T, T, G0, F, F, T);
    // x0 discard and pending lookup on addr 7
    addVec(T, T, 5'd0,  32'hDEAD,   F, 5'd0,  32'h0,      5'd7,  5'd0,  T, T, G0, F, F, T);
    addVec(T, T, 5'd7,  32'h7777,   F, 5'd0,  32'h0,      5'd7,  5'd0,  T, T, G0, F, F, T);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd7,  5'd0,  T, T, GA, T, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd7,  5'd0,  T, T, G0, F, F, T);
    // Full/backpressure: B wins the first tie, A fills to 2, third A entry waits for A's first pop
    addVec(T, T, 5'd8,  32'hA008,   T, 5'd21, 32'hB021,   5'd9,  5'd22, T, T, G0, F, F, T);
    addVec(T, T, 5'd9,  32'hA009,   T, 5'd22, 32'hB022,   5'd9,  5'd22, T, T, GB, F, F, F);
    addVec(T, T, 5'd10, 32'hA010,   T, 5'd23, 32'hB023,   5'd9,  5'd22, F, T, GA, T, T, F);
    addVec(T, T, 5'd10, 32'hA010,   T, 5'd24, 32'hB024,   5'd9,  5'd22, T, F, GB, T, T, F);
    addVec(T, F, 5'd0,  32'h0,      T, 5'd24, 32'hB024,   5'd9,  5'd22, F, T, GA, T, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd9,  5'd22, T, F, GB, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd9,  5'd22, T, T, GA, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd9,  5'd22, T, T, GB, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd9,  5'd22, T, T, G0, F, F, T);
    // Pause: two entries queued, rdy low for 3 cycles with A still offering, then resume in order
    addVec(T, T, 5'd30, 32'hA030,   T, 5'd40, 32'hB040,   5'd30, 5'd40, T, T, G0, F, F, T);
    addVec(F, T, 5'd31, 32'hA031,   F, 5'd0,  32'h0,      5'd30, 5'd40, F, F, G0, T, T, F);
    addVec(F, T, 5'd31, 32'hA031,   F, 5'd0,  32'h0,      5'd30, 5'd40, F, F, G0, T, T, F);
    addVec(F, T, 5'd31, 32'hA031,   F, 5'd0,  32'h0,      5'd30, 5'd40, F, F, G0, T, T, F);
    addVec(T, T, 5'd31, 32'hA031,   F, 5'd0,  32'h0,      5'd30, 5'd40, T, T, GA, T, T, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd30, 5'd40, T, T, GB, F, T, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd30, 5'd40, T, T, GA, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd30, 5'd40, T, T, G0, F, F, T);
    // Queue two entries that the reset pulse below must discard
    addVec(T, T, 5'd50, 32'hA050,   T, 5'd60, 32'hB060,   5'd50, 5'd60, T, T, G0, F, F, T);
    segEnd = vecs.size() - 1;
    // After the reset pulse: rr_last is back to B, so A wins the tie
    addVec(T, T, 5'd70, 32'hA070,   T, 5'd80, 32'hB080,   5'd0,  5'd0,  T, T, G0, F, F, T);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd0,  5'd0,  T, T, GA, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd0,  5'd0,  T, T, GB, F, F, F);
    addVec(T, F, 5'd0,  32'h0,      F, 5'd0,  32'h0,      5'd0,  5'd0,  T, T, G0, F, F, T);

    // Reset held with A offering a write: nothing handshakes, port quiet
    rst_n   = 1'b0;
    rdy     = 1'b1;
    a_valid = 1'b1;
    a_addr  = 5'd3;
    a_data  = 32'h3333;
    b_valid = 1'b0;
    b_addr  = 5'd0;
    b_data  = 32'h0;
    q1_addr = 5'd3;
    q2_addr = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare("reset we", 32'(we), 32'd0);
    compare("reset a_ready", 32'(a_ready), 32'd0);
    compare("reset b_ready", 32'(b_ready), 32'd0);
    compare("reset idle", 32'(idle), 32'd1);
    compare("reset q1_pend", 32'(q1_pend), 32'd0);
    compare("reset waddr", 32'(waddr), 32'd0);
    compare("reset wdata", wdata, 32'd0);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    compare("release a_ready", 32'(a_ready), 32'd1);
    compare("release b_ready", 32'(b_ready), 32'd1);
    compare("release idle", 32'(idle), 32'd1);

    runRows(0, segEnd);

    // Reset pulse with A50/B60 queued: everything drops immediately, queue is lost
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1;
    compare("prepulse q1_pend", 32'(q1_pend), 32'd1);
    compare("prepulse idle", 32'(idle), 32'd0);
    rst_n = 1'b0;
    #1;
    compare("pulse we", 32'(we), 32'd0);
    compare("pulse a_ready", 32'(a_ready), 32'd0);
    compare("pulse b_ready", 32'(b_ready), 32'd0);
    compare("pulse idle", 32'(idle), 32'd1);
    compare("pulse q1_pend", 32'(q1_pend), 32'd0);
    compare("pulse q2_pend", 32'(q2_pend), 32'd0);
    compare("pulse waddr", 32'(waddr), 32'd0);
    sbA.delete();
    sbB.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    compare("postpulse a_ready", 32'(a_ready), 32'd1);
    compare("postpulse idle", 32'(idle), 32'd1);
    compare("postpulse we", 32'(we), 32'd0);

    runRows(segEnd + 1, vecs.size() - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
